exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the operand and result width.
REQ-002 The block SHALL have parameter ADDR_W, default 2, the register-address width (4 registers).
REQ-003 The block SHALL have these ports: clk, in, 1, clock; reset, in, 1, reset, asynchronous, active-high.
REQ-004 The block SHALL have these ports: in_valid, in, 1, operation offered; in_ready, out, 1, operation accepted when in_valid and in_ready are both high at a posedge.
REQ-005 The block SHALL have these ports: op, in, 3, opcode; dest, in, ADDR_W, destination register.
REQ-006 The block SHALL have these ports: op_a and op_b, in, WIDTH, operands, the registered register-file read data.
REQ-007 The block SHALL have these ports: wb_write, out, 1, writeback strobe; wb_addr, out, ADDR_W; wb_data, out, WIDTH.
REQ-008 The block SHALL have these ports: flag_z, out, 1, zero flag; flag_c, out, 1, carry/borrow flag; busy, out, 1.

Function
REQ-009 Opcodes SHALL be: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SHL a by b[3:0], 110 SHR logical a by b[3:0], 111 MUL (low WIDTH bits of a*b).
REQ-010 The FSM SHALL have states IDLE, MUL, WB; in_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-011 On accept in IDLE: op, dest, op_a and op_b SHALL be captured, and next state SHALL be WB for opcodes 000-110 and MUL for 111.
REQ-012 For non-MUL ops, the result SHALL be computed from the captured operands; wb_write SHALL be high for exactly the one cycle in WB, i.e. the cycle after accept.
REQ-013 MUL SHALL be an iterative shift-add: one multiplier bit per cycle, LSB first, for exactly WIDTH cycles in MUL, then WB; wb_write SHALL be high WIDTH+1 cycles after accept.
REQ-014 WB SHALL always return to IDLE after one cycle, giving a throughput of at most one op per 2 cycles.
REQ-015 wb_addr and wb_data SHALL be registered and stable throughout the WB cycle; outside WB, wb_write SHALL be 0 and wb_addr/wb_data SHALL hold their last values.
REQ-016 ADD/SUB arithmetic SHALL be WIDTH+1 bits wide: flag_c = carry-out for ADD and borrow (a<b unsigned) for SUB.
REQ-017 flag_c SHALL be unchanged by all other ops.
REQ-018 flag_z SHALL be set to (result==0) for every op, updated in the WB cycle.
REQ-019 Shift amounts of 0 SHALL return a unchanged; shift amounts of 15 SHALL leave one bit.
REQ-020 MUL overflow above WIDTH bits SHALL be discarded silently.
REQ-021 in_valid while busy SHALL be ignored, with no capture and no state change; the upstream holds the op.
REQ-022 Operands SHALL be sampled only at accept; later changes to op_a/op_b SHALL NOT affect an in-flight op.
REQ-023 A dest equal to a source register SHALL be legal; the write lands on the register file's negedge in the WB cycle.

Reset
REQ-024 Asserting reset at any time, including mid-MUL or in WB, SHALL force state IDLE, wb_write 0, wb_addr 0, wb_data 0, flag_z 0, flag_c 0 and clear the MUL accumulator and counter.
REQ-025 The in-flight op SHALL be dropped with no writeback; after reset deasserts, in_ready SHALL be 1 on the first cycle.

Structure
REQ-026 The opcode enum, state enum, and WIDTH/ADDR_W defaults SHALL live in shared package tinychip_pkg.
REQ-027 The combinational ADD/SUB/logic/shift datapath SHALL be one sub-module, alu_comb, with inputs a, b and op, and outputs result and carry.
REQ-028 The FSM, capture registers and iterative multiplier SHALL reside in exec_unit.

Verification
REQ-029 ADD a=16'hFFFF, b=1, dest=2 -> next cycle wb_write=1, wb_addr=2, wb_data=0, flag_z=1, flag_c=1.
REQ-030 SUB a=3, b=5 -> wb_data=16'hFFFE, flag_c=1, flag_z=0; then AND a=16'hF0F0, b=16'h0FF0 -> wb_data=16'h00F0, flag_c still 1.
REQ-031 MUL a=300, b=300 -> in_ready low for 17 cycles, wb_write at accept+17, wb_data=16'h5F90 (90000 mod 65536).
REQ-032 SHL a=1, b=15 -> 16'h8000; SHR a=16'h8000, b=16'h0010 -> 16'h8000 (b[3:0]=0, unchanged).
REQ-033 Reset asserted at MUL cycle 8 -> no wb_write at any point, all outputs 0, in_ready=1 on the first cycle after release.
REQ-034 in_valid held high continuously with a back-to-back ADD stream -> accepts every second cycle, one wb_write per op, operands not resampled while busy.

Source files
------------

// File: rtl/tinychip_pkg.sv
// Shared definitions for the tinychip execution path: opcodes, FSM states and
// default datapath widths.
package tinychip_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_WB   = 2'b10
    } state_e;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU for every opcode except MUL; carry is the WIDTH+1 bit of
// ADD/SUB and zero otherwise.
module alu_comb
    import tinychip_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;
    logic [3:0]     shamt_s;

    assign sum_s   = {1'b0, a} + {1'b0, b};
    assign diff_s  = {1'b0, a} - {1'b0, b};
    assign shamt_s = b[3:0];

    // Opcode decode of the combinational result and carry/borrow.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum_s[WIDTH-1:0];
                carry  = sum_s[WIDTH];
            end
            OP_SUB: begin
                result = diff_s[WIDTH-1:0];
                carry  = diff_s[WIDTH];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << shamt_s;
            OP_SHR:  result = a >> shamt_s;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// Execution unit: accepts one operation at a time, runs ALU ops in one cycle
// and MUL as a WIDTH-cycle shift-add, then presents a one-cycle writeback.
module exec_unit
    import tinychip_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] dest,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    output logic              wb_write,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]  wb_data,
    output logic              flag_z,
    output logic              flag_c,
    output logic              busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wb_write_q, wb_write_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0]  wb_data_q, wb_data_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_c_q, flag_c_d;

    logic              accept_s;
    logic              mul_done_s;
    logic              wb_load_s;
    logic [WIDTH-1:0]  acc_next_s;
    logic [WIDTH-1:0]  alu_result_s;
    logic              alu_carry_s;
    logic [WIDTH-1:0]  result_s;

    assign accept_s   = in_valid && (state_q == ST_IDLE);
    assign mul_done_s = (state_q == ST_MUL) && (cnt_q == CNT_W'(WIDTH - 1));
    // a_q is the multiplicand shifted left, b_q the multiplier shifted right.
    assign acc_next_s = acc_q + (b_q[0] ? a_q : '0);

    // The ALU sees the values being captured, so its result lands in WB.
    alu_comb #(.WIDTH(WIDTH)) u_alu (
        .a      (a_d),
        .b      (b_d),
        .op     (op_d),
        .result (alu_result_s),
        .carry  (alu_carry_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = (op == OP_MUL) ? ST_MUL : ST_WB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        in_ready = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
    end

    // Capture registers and multiplier step next-state.
    always_comb begin
        op_d   = op_q;
        dest_d = dest_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        if (accept_s) begin
            op_d   = op;
            dest_d = dest;
            a_d    = op_a;
            b_d    = op_b;
            acc_d  = '0;
            cnt_d  = '0;
        end else if (state_q == ST_MUL) begin
            acc_d = acc_next_s;
            a_d   = {a_q[WIDTH-2:0], 1'b0};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            acc_d = acc_q;
        end
    end

    // Writeback and flag next-state; flag_c only moves on ADD/SUB.
    always_comb begin
        wb_load_s  = (accept_s && (op != OP_MUL)) || mul_done_s;
        result_s   = mul_done_s ? acc_next_s : alu_result_s;
        wb_write_d = wb_load_s;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        flag_z_d   = flag_z_q;
        flag_c_d   = flag_c_q;
        if (wb_load_s) begin
            wb_addr_d = dest_d;
            wb_data_d = result_s;
            flag_z_d  = (result_s == '0);
            if ((op_d == OP_ADD) || (op_d == OP_SUB)) begin
                flag_c_d = alu_carry_s;
            end else begin
                flag_c_d = flag_c_q;
            end
        end else begin
            wb_addr_d = wb_addr_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= 3'b000;
            dest_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            wb_write_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
        end else begin
            op_q       <= op_d;
            dest_q     <= dest_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wb_write_q <= wb_write_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            flag_z_q   <= flag_z_d;
            flag_c_q   <= flag_c_d;
        end
    end

    assign wb_write = wb_write_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed cases, reset mid-multiply,
// randomized ops and a back-to-back stream against an arithmetic model.
module tb_exec_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [1:0]  dest;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        wb_write;
    logic [1:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flag_z;
    logic        flag_c;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic        fc_m;
    logic        fz_m;
    logic [15:0] data_m;
    logic [1:0]  addr_m;

    exec_unit #(.WIDTH(16), .ADDR_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .dest     (dest),
        .op_a     (op_a),
        .op_b     (op_b),
        .wb_write (wb_write),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {carry, result} from plain integer arithmetic.
    function automatic logic [16:0] ref_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        longint unsigned x, y, r;
        int sh;
        logic c;
        x = a;
        y = b;
        sh = int'(y % 16);
        c = 1'b0;
        case (o)
            3'd0: begin r = x + y; c = (r > 65535); end
            3'd1: begin r = x + 65536 - y; c = (x < y); end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = x * (longint'(1) << sh);
            3'd6: r = x / (longint'(1) << sh);
            default: r = x * y;
        endcase
        r = r % 65536;
        return {c, r[15:0]};
    endfunction

    task automatic model_apply(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input logic [1:0] d);
        logic [16:0] cr;
        cr = ref_op(o, a, b);
        data_m = cr[15:0];
        addr_m = d;
        fz_m = (cr[15:0] == 16'd0);
        if (o == 3'd0 || o == 3'd1) fc_m = cr[16];
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input logic [1:0] d);
        int lat;
        int wait_cnt;
        wait_cnt = 0;
        while (in_ready !== 1'b1 && wait_cnt < 40) begin
            tick();
            wait_cnt++;
        end
        check({tag, "_ready"}, in_ready, 1);
        in_valid = 1'b1;
        op = o;
        op_a = a;
        op_b = b;
        dest = d;
        model_apply(o, a, b, d);
        tick();
        in_valid = 1'b0;
        op = 3'($urandom);
        op_a = 16'($urandom);
        op_b = 16'($urandom);
        dest = 2'($urandom);
        lat = 1;
        while (wb_write !== 1'b1 && lat < 40) begin
            check({tag, "_busy_ready"}, in_ready, 0);
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, (o == 3'd7) ? 17 : 1);
        check({tag, "_addr"}, wb_addr, addr_m);
        check({tag, "_data"}, wb_data, data_m);
        check({tag, "_z"}, flag_z, fz_m);
        check({tag, "_c"}, flag_c, fc_m);
        check({tag, "_wb_busy"}, busy, 1);
        tick();
        check({tag, "_wb_drop"}, wb_write, 0);
        check({tag, "_hold"}, wb_data, data_m);
        check({tag, "_idle"}, in_ready, 1);
    endtask

    initial begin
        int seen;
        logic [2:0] ro;
        logic [15:0] ra, rb;
        reset = 1'b1;
        in_valid = 1'b0;
        op = 3'd0;
        dest = 2'd0;
        op_a = 16'd0;
        op_b = 16'd0;
        fc_m = 1'b0;
        fz_m = 1'b0;
        data_m = 16'd0;
        addr_m = 2'd0;
        tick();
        tick();
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_wb", wb_write, 0);
        check("rst_data", wb_data, 0);
        check("rst_flags", {flag_z, flag_c}, 0);
        reset = 1'b0;
        tick();

        run_op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 2'd2);
        check("add_wrap_abs", {flag_z, flag_c, wb_data}, {2'b11, 16'h0000});
        run_op("sub_borrow", 3'd1, 16'd3, 16'd5, 2'd1);
        check("sub_abs", {flag_z, flag_c, wb_data}, {2'b01, 16'hFFFE});
        run_op("and_keepc", 3'd2, 16'hF0F0, 16'h0FF0, 2'd3);
        check("and_abs", {flag_c, wb_data}, {1'b1, 16'h00F0});
        run_op("shl15", 3'd5, 16'h0001, 16'd15, 2'd0);
        check("shl15_abs", wb_data, 16'h8000);
        run_op("shr0", 3'd6, 16'h8000, 16'h0010, 2'd1);
        check("shr0_abs", wb_data, 16'h8000);
        run_op("mul300", 3'd7, 16'd300, 16'd300, 2'd2);
        check("mul300_abs", wb_data, 16'h5F90);

        // Reset in the middle of a multiply drops it entirely.
        in_valid = 1'b1;
        op = 3'd7;
        op_a = 16'h1234;
        op_b = 16'h00FF;
        dest = 2'd3;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        check("mid_mul_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_outs", {wb_write, wb_addr, wb_data, flag_z, flag_c}, 0);
        check("rst_mid_ready", in_ready, 1);
        tick();
        reset = 1'b0;
        #1;
        check("rel_ready", in_ready, 1);
        check("rel_outs", {wb_write, wb_addr, wb_data, flag_z, flag_c, busy}, 0);
        fc_m = 1'b0;
        fz_m = 1'b0;
        data_m = 16'd0;
        addr_m = 2'd0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wb_write === 1'b1) seen++;
        end
        check("rst_no_wb", seen, 0);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 1)) * 16'd15;
            if ($urandom_range(0, 5) == 0) ra = 16'd0;
            run_op("rand", ro, ra, rb, 2'($urandom));
        end

        // Continuous in_valid with ADDs: one accept every second cycle.
        in_valid = 1'b1;
        op = 3'd0;
        op_a = 16'($urandom);
        op_b = 16'($urandom);
        dest = 2'($urandom);
        for (int k = 0; k < 6; k++) begin
            check("b2b_ready", in_ready, 1);
            model_apply(3'd0, op_a, op_b, dest);
            tick();
            op_a = 16'($urandom);
            op_b = 16'($urandom);
            dest = 2'($urandom);
            check("b2b_wb", wb_write, 1);
            check("b2b_busy", in_ready, 0);
            check("b2b_data", wb_data, data_m);
            check("b2b_addr", wb_addr, addr_m);
            check("b2b_flags", {flag_z, flag_c}, {fz_m, fc_m});
            tick();
            check("b2b_gap", wb_write, 0);
            check("b2b_hold", wb_data, data_m);
        end
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
